// File: rtl/my_mod_pkg.sv
// Shared definitions for the windowed sample statistics unit.
//   DATA_W  sample width
//   CNT_W   window counter width
//   state_t window FSM states
//   acc_w() sum width that cannot overflow for a given scale/window size
package my_mod_pkg;
  localparam int DATA_W = 9;
  localparam int CNT_W  = 8;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic int acc_w(input int x, input int y);
    return DATA_W + x + $clog2(y + 1);
  endfunction
endpackage

// File: rtl/my_mod_minmax.sv
// Running unsigned min/max tracker with clear.
//   clk, rst  clock and synchronous active-high reset
//   clr       return trackers to their empty values (min=1FF, max=0)
//   en, d     sample strobe and sample value
//   min_nxt   min including the current sample (combinational)
//   max_nxt   max including the current sample (combinational)
module my_mod_minmax
  import my_mod_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] min_nxt,
  output logic [DATA_W-1:0] max_nxt
);
  logic [DATA_W-1:0] min_q, max_q;

  always_comb begin
    min_nxt = min_q;
    max_nxt = max_q;
    if (en) begin
      if (d < min_q) min_nxt = d;
      if (d > max_q) max_nxt = d;
    end
  end

  // A clear in the same cycle as a sample wins: that sample was already
  // folded into the emitted result through min_nxt/max_nxt.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end
endmodule

// File: rtl/my_mod.sv
// Windowed sample statistics unit.
// Accumulates scaled sum, min, max and parity over Y samples (or until a
// flush) and presents the results with a one-cycle done pulse.
//   clk, rst   clock, synchronous active-high reset
//   foo        9-bit sample, foo_valid strobe (no backpressure)
//   flush      close the current window early
//   sum_out    sum of (sample << X); min_out/max_out unsigned extremes
//   par_out    XOR of all sample bits; count_out samples in window
//   done       one-cycle pulse when outputs are updated
module my_mod
  import my_mod_pkg::*;
#(
  parameter  int X     = 1,
  parameter  int Y     = 2,
  localparam int ACC_W = acc_w(X, Y)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] foo,
  input  logic              foo_valid,
  input  logic              flush,
  output logic [ACC_W-1:0]  sum_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              par_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              done
);
  state_t             state;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               par, par_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_nxt;
  logic               close;
  logic [DATA_W-1:0]  min_nxt, max_nxt;

  my_mod_minmax u_minmax (
    .clk     (clk),
    .rst     (rst),
    .clr     (close),
    .en      (foo_valid),
    .d       (foo),
    .min_nxt (min_nxt),
    .max_nxt (max_nxt)
  );

  // Window values including this cycle's sample, used both to advance the
  // accumulators and to load the result registers on a closing cycle.
  always_comb begin
    acc_nxt = acc;
    par_nxt = par;
    cnt_nxt = {1'b0, cnt};
    if (foo_valid) begin
      acc_nxt = acc + (ACC_W'(foo) << X);
      par_nxt = par ^ (^foo);
      cnt_nxt = {1'b0, cnt} + 1'b1;
    end
    // Flush only closes a non-empty window; a same-cycle sample counts.
    close = (foo_valid && (cnt_nxt == (CNT_W+1)'(Y))) ||
            (flush && ((state == ACCUM) || foo_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      par       <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      min_out   <= '0;
      max_out   <= '0;
      par_out   <= 1'b0;
      count_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= close;
      if (close) begin
        sum_out   <= acc_nxt;
        min_out   <= min_nxt;
        max_out   <= max_nxt;
        par_out   <= par_nxt;
        count_out <= cnt_nxt[CNT_W-1:0];
        acc       <= '0;
        par       <= 1'b0;
        cnt       <= '0;
        state     <= IDLE;
      end else begin
        acc <= acc_nxt;
        par <= par_nxt;
        cnt <= cnt_nxt[CNT_W-1:0];
        if (foo_valid) state <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_my_mod.sv
// Bench for my_mod: five parameterisations share one stimulus stream; a
// window-buffer reference model predicts every output on every cycle.
module tb_my_mod;
  import my_mod_pkg::*;

  localparam int ND = 5;
  localparam int XS [ND] = '{1, 3, 1, 1, 2};
  localparam int YS [ND] = '{2, 2, 4, 1, 5};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] foo = '0;
  logic       foo_valid = 1'b0;
  logic       flush = 1'b0;

  logic [31:0] g_sum [ND];
  logic [31:0] g_min [ND];
  logic [31:0] g_max [ND];
  logic [31:0] g_par [ND];
  logic [31:0] g_cnt [ND];
  logic [31:0] g_done[ND];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    logic [acc_w(XS[gi], YS[gi])-1:0] s;
    logic [8:0] mn, mx;
    logic       p, d;
    logic [7:0] c;
    my_mod #(.X(XS[gi]), .Y(YS[gi])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .foo       (foo),
      .foo_valid (foo_valid),
      .flush     (flush),
      .sum_out   (s),
      .min_out   (mn),
      .max_out   (mx),
      .par_out   (p),
      .count_out (c),
      .done      (d)
    );
    assign g_sum[gi]  = 32'(s);
    assign g_min[gi]  = 32'(mn);
    assign g_max[gi]  = 32'(mx);
    assign g_par[gi]  = 32'(p);
    assign g_cnt[gi]  = 32'(c);
    assign g_done[gi] = 32'(d);
  end

  // Reference model: the open window is kept as a list of raw samples and
  // the statistics are computed from that list when the window closes.
  int wbuf [ND][256];
  int wn   [ND];
  int e_sum[ND], e_min[ND], e_max[ND], e_par[ND], e_cnt[ND], e_done[ND];

  task automatic model_step(input bit r, input bit v, input int smp, input bit f);
    for (int d = 0; d < ND; d++) begin
      if (r) begin
        wn[d] = 0;
        e_sum[d] = 0; e_min[d] = 0; e_max[d] = 0;
        e_par[d] = 0; e_cnt[d] = 0; e_done[d] = 0;
      end else begin
        if (v) begin
          wbuf[d][wn[d]] = smp;
          wn[d]++;
        end
        if ((v && wn[d] == YS[d]) || (f && wn[d] > 0)) begin
          e_sum[d] = 0; e_min[d] = 511; e_max[d] = 0; e_par[d] = 0;
          for (int k = 0; k < wn[d]; k++) begin
            e_sum[d] += wbuf[d][k] * (1 << XS[d]);
            if (wbuf[d][k] < e_min[d]) e_min[d] = wbuf[d][k];
            if (wbuf[d][k] > e_max[d]) e_max[d] = wbuf[d][k];
            e_par[d] ^= $countones(wbuf[d][k]) & 1;
          end
          e_cnt[d]  = wn[d];
          e_done[d] = 1;
          wn[d]     = 0;
        end else begin
          e_done[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d.done", d), g_done[d], 32'(e_done[d]));
      chk($sformatf("d%0d.sum",  d), g_sum[d],  32'(e_sum[d]));
      chk($sformatf("d%0d.min",  d), g_min[d],  32'(e_min[d]));
      chk($sformatf("d%0d.max",  d), g_max[d],  32'(e_max[d]));
      chk($sformatf("d%0d.par",  d), g_par[d],  32'(e_par[d]));
      chk($sformatf("d%0d.cnt",  d), g_cnt[d],  32'(e_cnt[d]));
    end
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, then check.
  task automatic cyc(input bit r, input bit v, input int smp, input bit f);
    rst = r; foo_valid = v; foo = 9'(smp); flush = f;
    @(posedge clk);
    model_step(r, v, smp, f);
    #1;
    check_all();
  endtask

  initial begin
    for (int d = 0; d < ND; d++) wn[d] = 0;
    #1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst.sum", g_sum[0], 0);
    chk("rst.done", g_done[0], 0);

    // 5,7 with X=1,Y=2
    cyc(0, 1, 5, 0);
    cyc(0, 1, 7, 0);
    chk("d0.5_7.done", g_done[0], 1);
    chk("d0.5_7.sum", g_sum[0], 24);
    chk("d0.5_7.min", g_min[0], 5);
    chk("d0.5_7.max", g_max[0], 7);
    chk("d0.5_7.par", g_par[0], 1);
    chk("d0.5_7.cnt", g_cnt[0], 2);
    cyc(0, 0, 0, 0);
    chk("d0.hold.done", g_done[0], 0);
    chk("d0.hold.sum", g_sum[0], 24);

    // 1FF twice with X=3,Y=2
    cyc(1, 0, 0, 0);
    cyc(0, 1, 511, 0);
    cyc(0, 1, 511, 0);
    chk("d1.ff.sum", g_sum[1], 8176);
    chk("d1.ff.min", g_min[1], 511);
    chk("d1.ff.max", g_max[1], 511);
    chk("d1.ff.par", g_par[1], 0);

    // Y=4: sample 0 then flush, then idle flush
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk("d2.fl.done", g_done[2], 1);
    chk("d2.fl.sum", g_sum[2], 0);
    chk("d2.fl.cnt", g_cnt[2], 1);
    cyc(0, 0, 0, 1);
    chk("d2.idlefl.done", g_done[2], 0);

    // 1,2,3,4 back-to-back on Y=2
    cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 0);
    chk("d0.b2b1.sum", g_sum[0], 6);
    cyc(0, 1, 3, 0);
    chk("d0.b2b.gap", g_done[0], 0);
    cyc(0, 1, 4, 0);
    chk("d0.b2b2.done", g_done[0], 1);
    chk("d0.b2b2.sum", g_sum[0], 14);

    // reset mid-window then 8,8
    cyc(0, 1, 100, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 8, 0);
    cyc(0, 1, 8, 0);
    chk("d0.rst.sum", g_sum[0], 32);
    chk("d0.rst.cnt", g_cnt[0], 2);

    // Y=1: every sample emits
    cyc(0, 1, 3, 0);
    chk("d3.y1.done", g_done[3], 1);
    chk("d3.y1.sum", g_sum[3], 6);
    chk("d3.y1.par", g_par[3], 0);
    cyc(0, 1, 3, 1);
    chk("d3.y1b.done", g_done[3], 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, v, f;
      int s;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: s = 0;
        1: s = 511;
        default: s = int'($urandom_range(0, 511));
      endcase
      cyc(r, v, s, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
